// File: rtl/rt_types_pkg.sv
// Shared ray-tracer scene types: 32.32 fixed-point vectors, 8-bit RGB colours and
// the sphere-reader snapshot entry / FSM state.
package rt_types_pkg;

    localparam int unsigned N_SPHERES_DEF = 4;

    typedef logic signed [63:0] fixed_real_t;

    typedef struct packed {
        fixed_real_t x;
        fixed_real_t y;
        fixed_real_t z;
    } vector_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    typedef struct packed {
        vector_t pos;
        color_t  col;
    } snap_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStream
    } scan_state_e;

endpackage

// File: rtl/sphere_scene_reader_if.sv
// Bank-read and snapshot-stream signals of the sphere scene reader.
interface sphere_scene_reader_if
    import rt_types_pkg::*;
#(
    parameter int unsigned N_SPHERES = N_SPHERES_DEF,
    parameter int unsigned IDX_W     = $clog2(N_SPHERES)
) ();

    logic             Frame_Start;
    logic [IDX_W-1:0] Read_index;
    vector_t          Sphere_pos;
    color_t           Sphere_col;
    logic             Scan_req;
    logic             Scan_busy;
    logic             Snap_valid;
    logic             Out_valid;
    logic             Out_ready;
    logic [IDX_W-1:0] Out_index;
    vector_t          Out_pos;
    color_t           Out_col;
    logic             Out_last;

    modport master (
        input  Frame_Start, Sphere_pos, Sphere_col, Scan_req, Out_ready,
        output Read_index, Scan_busy, Snap_valid, Out_valid, Out_index, Out_pos, Out_col,
               Out_last
    );

    modport slave (
        output Frame_Start, Sphere_pos, Sphere_col, Scan_req, Out_ready,
        input  Read_index, Scan_busy, Snap_valid, Out_valid, Out_index, Out_pos, Out_col,
               Out_last
    );

endinterface

// File: rtl/sphere_snap_buf.sv
// Private per-frame sphere snapshot: one write port for the fetch walk, one
// combinational read port for the stream.
module sphere_snap_buf
    import rt_types_pkg::*;
#(
    parameter int unsigned N_SPHERES = N_SPHERES_DEF,
    parameter int unsigned IDX_W     = $clog2(N_SPHERES)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  snap_entry_t      wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output snap_entry_t      rd_data_o
);

    snap_entry_t mem_q [N_SPHERES];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(N_SPHERES); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/sphere_scene_reader.sv
// Snapshots the sphere bank on each frame pulse and streams that frozen snapshot
// to the intersection pipeline on request, so one stream never mixes two frames.
module sphere_scene_reader
    import rt_types_pkg::*;
#(
    parameter int unsigned N_SPHERES = N_SPHERES_DEF,
    parameter int unsigned IDX_W     = $clog2(N_SPHERES),
    parameter int unsigned READ_LAT  = 0
) (
    input logic                   Clk,
    input logic                   Reset,
    sphere_scene_reader_if.master bus
);

    localparam int unsigned      LAT_W    = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPHERES - 1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(READ_LAT);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             pending_q, pending_d;
    logic             snap_valid_q, snap_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    snap_entry_t      out_beat_q, out_beat_d;

    logic             buf_we;
    logic [IDX_W-1:0] buf_rd_idx;
    snap_entry_t      buf_rd_data;

    sphere_snap_buf #(
        .N_SPHERES (N_SPHERES),
        .IDX_W     (IDX_W)
    ) u_snap_buf (
        .Clk       (Clk),
        .Reset     (Reset),
        .wr_en_i   (buf_we),
        .wr_idx_i  (rd_idx_q),
        .wr_data_i ({bus.Sphere_pos, bus.Sphere_col}),
        .rd_idx_i  (buf_rd_idx),
        .rd_data_o (buf_rd_data)
    );

    always_comb begin
        state_d      = state_q;
        rd_idx_d     = rd_idx_q;
        lat_d        = lat_q;
        pending_d    = pending_q;
        snap_valid_d = snap_valid_q;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_beat_d   = out_beat_q;
        buf_we       = 1'b0;
        // Read port pre-addresses the beat that follows the one being presented.
        buf_rd_idx   = out_valid_q ? out_idx_q + IDX_W'(1) : '0;

        unique case (state_q)
            StIdle: begin
                if (bus.Frame_Start || pending_q) begin
                    state_d   = StFetch;
                    rd_idx_d  = '0;
                    lat_d     = '0;
                    pending_d = 1'b0;
                end else if (bus.Scan_req && snap_valid_q) begin
                    state_d = StStream;
                end
            end
            StFetch: begin
                if (bus.Frame_Start) pending_d = 1'b1;
                if (lat_q == LAST_LAT) begin
                    buf_we = 1'b1;
                    lat_d  = '0;
                    if (rd_idx_q == LAST_IDX) begin
                        snap_valid_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            StStream: begin
                if (bus.Frame_Start) pending_d = 1'b1;
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = '0;
                    out_beat_d  = buf_rd_data;
                end else if (bus.Out_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        state_d     = StIdle;
                    end else begin
                        out_idx_d  = out_idx_q + IDX_W'(1);
                        out_beat_d = buf_rd_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            rd_idx_q     <= '0;
            lat_q        <= '0;
            pending_q    <= 1'b0;
            snap_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_beat_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_idx_q     <= rd_idx_d;
            lat_q        <= lat_d;
            pending_q    <= pending_d;
            snap_valid_q <= snap_valid_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_beat_q   <= out_beat_d;
        end
    end

    assign bus.Read_index = rd_idx_q;
    assign bus.Scan_busy  = (state_q != StIdle);
    assign bus.Snap_valid = snap_valid_q;
    assign bus.Out_valid  = out_valid_q;
    assign bus.Out_index  = out_idx_q;
    assign bus.Out_pos    = out_beat_q.pos;
    assign bus.Out_col    = out_beat_q.col;
    assign bus.Out_last   = (out_idx_q == LAST_IDX);

endmodule
